// File: rtl/exc_stage_e.sv
// exc_stage_e: execute-stage exception merge and E/M exception pipeline register.
// Combines the exception code inherited from D with the E-stage sources:
// arithmetic overflow, load/store address errors and generic external requests.
// The merged code, delay-slot flag, EPC and BadVAddr are registered into M.
// Once an exception is accepted, younger instructions are turned into bubbles
// until a flush arrives.
// Optional feature macro: EXC_STAGE_STATS_EN (adds exc_count and last_code).

module exc_stage_e #(
    parameter int         AW       = 32,
    parameter int         N_EXT    = 2,
    parameter logic [4:0] EXC_OV   = 5'd12,
    parameter logic [4:0] EXC_ADEL = 5'd4,
    parameter logic [4:0] EXC_ADES = 5'd5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               valid_e,
    input  logic               bd_d,
    input  logic [4:0]         exccode_d,
    input  logic [AW-1:0]      pc_e,
    input  logic               arith_trap,
    input  logic               ovf,
    input  logic               mem_rd,
    input  logic               mem_wr,
    input  logic [1:0]         mem_size,
    input  logic [AW-1:0]      addr,
    input  logic               addr_ovf,
    input  logic [N_EXT-1:0]   ext_req,
    input  logic [5*N_EXT-1:0] ext_code,
    output logic [4:0]         exccode_e,
    output logic               exc_m,
    output logic [4:0]         exccode_m,
    output logic               bd_m,
    output logic [AW-1:0]      epc_m,
    output logic [AW-1:0]      badvaddr_m,
    output logic               valid_m,
    output logic               shadow
`ifdef EXC_STAGE_STATS_EN
    ,
    output logic [15:0]        exc_count,
    output logic [4:0]         last_code
`endif
);

    logic          misaligned;
    logic          addr_fault;
    logic          ext_hit;
    logic [4:0]    ext_code_sel;
    logic [4:0]    raw_code;
    logic [AW-1:0] bad_sel;
    logic          valid_next;
    logic          exc_e;
    logic          load_en;

    // Alignment check by access size; byte accesses can never be misaligned
    always_comb begin
        misaligned = 1'b0;
        case (mem_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            default: misaligned = |addr[1:0];
        endcase
        addr_fault = addr_ovf | misaligned;
    end

    // Pick the lowest-index external request that carries a nonzero code
    always_comb begin
        ext_hit      = 1'b0;
        ext_code_sel = 5'd0;
        for (int i = 0; i < N_EXT; i++) begin
            if (!ext_hit && ext_req[i] && (ext_code[5*i +: 5] != 5'd0)) begin
                ext_hit      = 1'b1;
                ext_code_sel = ext_code[5*i +: 5];
            end
        end
    end

    // Priority merge of all exception sources and choice of the faulting address
    always_comb begin
        raw_code = 5'd0;
        bad_sel  = '0;
        if (exccode_d != 5'd0) begin
            raw_code = exccode_d;
            if (exccode_d == EXC_ADEL) begin
                bad_sel = pc_e;
            end
        end else if (arith_trap && ovf) begin
            raw_code = EXC_OV;
        end else if (mem_rd && addr_fault) begin
            raw_code = EXC_ADEL;
            bad_sel  = addr;
        end else if (mem_wr && addr_fault) begin
            raw_code = EXC_ADES;
            bad_sel  = addr;
        end else if (ext_hit) begin
            raw_code = ext_code_sel;
        end
    end

    // Mask the merged code for bubbles and for instructions inside the shadow
    always_comb begin
        valid_next = valid_e & ~shadow;
        exccode_e  = valid_next ? raw_code : 5'd0;
        exc_e      = (exccode_e != 5'd0);
        load_en    = ~flush & ~stall;
    end

    // E/M pipeline register with flush over stall, plus the exception shadow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_m    <= 1'b0;
            exccode_m  <= 5'd0;
            exc_m      <= 1'b0;
            bd_m       <= 1'b0;
            epc_m      <= '0;
            badvaddr_m <= '0;
            shadow     <= 1'b0;
        end else if (flush) begin
            valid_m    <= 1'b0;
            exccode_m  <= 5'd0;
            exc_m      <= 1'b0;
            bd_m       <= 1'b0;
            epc_m      <= '0;
            badvaddr_m <= '0;
            shadow     <= 1'b0;
        end else if (!stall) begin
            valid_m    <= valid_next;
            exccode_m  <= exccode_e;
            exc_m      <= exc_e;
            bd_m       <= bd_d & valid_next;
            epc_m      <= exc_e ? pc_e : '0;
            badvaddr_m <= exc_e ? bad_sel : '0;
            if (exc_e) begin
                shadow <= 1'b1;
            end
        end
    end

`ifdef EXC_STAGE_STATS_EN
    // Saturating count of accepted exceptions and the most recent accepted code
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exc_count <= 16'd0;
            last_code <= 5'd0;
        end else if (load_en && exc_e) begin
            if (exc_count != 16'hFFFF) begin
                exc_count <= exc_count + 16'd1;
            end
            last_code <= exccode_e;
        end
    end
`endif

endmodule

// File: tb/tb_exc_stage_e.sv
// tb_exc_stage_e: directed self-checking bench for exc_stage_e.
// Inputs change on the falling edge; registered outputs are sampled 1ns
// after the rising edge. Stats checks are compiled when EXC_STAGE_STATS_EN is set.

module tb_exc_stage_e;

    localparam int AW    = 32;
    localparam int N_EXT = 2;

    logic               clk;
    logic               reset_n;
    logic               stall;
    logic               flush;
    logic               valid_e;
    logic               bd_d;
    logic [4:0]         exccode_d;
    logic [AW-1:0]      pc_e;
    logic               arith_trap;
    logic               ovf;
    logic               mem_rd;
    logic               mem_wr;
    logic [1:0]         mem_size;
    logic [AW-1:0]      addr;
    logic               addr_ovf;
    logic [N_EXT-1:0]   ext_req;
    logic [5*N_EXT-1:0] ext_code;
    logic [4:0]         exccode_e;
    logic               exc_m;
    logic [4:0]         exccode_m;
    logic               bd_m;
    logic [AW-1:0]      epc_m;
    logic [AW-1:0]      badvaddr_m;
    logic               valid_m;
    logic               shadow;
`ifdef EXC_STAGE_STATS_EN
    logic [15:0]        exc_count;
    logic [4:0]         last_code;
`endif

    int vectors;
    int miscompares;

    exc_stage_e #(
        .AW       (AW),
        .N_EXT    (N_EXT),
        .EXC_OV   (5'd12),
        .EXC_ADEL (5'd4),
        .EXC_ADES (5'd5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .flush      (flush),
        .valid_e    (valid_e),
        .bd_d       (bd_d),
        .exccode_d  (exccode_d),
        .pc_e       (pc_e),
        .arith_trap (arith_trap),
        .ovf        (ovf),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_size   (mem_size),
        .addr       (addr),
        .addr_ovf   (addr_ovf),
        .ext_req    (ext_req),
        .ext_code   (ext_code),
        .exccode_e  (exccode_e),
        .exc_m      (exc_m),
        .exccode_m  (exccode_m),
        .bd_m       (bd_m),
        .epc_m      (epc_m),
        .badvaddr_m (badvaddr_m),
        .valid_m    (valid_m),
        .shadow     (shadow)
`ifdef EXC_STAGE_STATS_EN
        ,
        .exc_count  (exc_count),
        .last_code  (last_code)
`endif
    );

    // Free-running 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one E-stage instruction on the falling edge
    task automatic applyStimulus(input logic v, input logic bd, input logic [4:0] dcode,
                                 input logic [AW-1:0] pc, input logic trap, input logic ov,
                                 input logic rd, input logic wr, input logic [1:0] size,
                                 input logic [AW-1:0] a, input logic aovf,
                                 input logic [N_EXT-1:0] ereq, input logic [5*N_EXT-1:0] ecode);
        @(negedge clk);
        valid_e    = v;
        bd_d       = bd;
        exccode_d  = dcode;
        pc_e       = pc;
        arith_trap = trap;
        ovf        = ov;
        mem_rd     = rd;
        mem_wr     = wr;
        mem_size   = size;
        addr       = a;
        addr_ovf   = aovf;
        ext_req    = ereq;
        ext_code   = ecode;
    endtask

    task automatic idleStimulus();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10,
                      32'h0, 1'b0, 2'b00, 10'd0);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [AW-1:0] observed,
                               input logic [AW-1:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One idle cycle with flush asserted to clear M and end the shadow
    task automatic flushCycle();
        idleStimulus();
        flush = 1'b1;
        stepCycle();
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Directed sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        valid_e     = 1'b0;
        bd_d        = 1'b0;
        exccode_d   = 5'd0;
        pc_e        = '0;
        arith_trap  = 1'b0;
        ovf         = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_size    = 2'b10;
        addr        = '0;
        addr_ovf    = 1'b0;
        ext_req     = '0;
        ext_code    = '0;

        // Reset state
        #12;
        checkOutput("rst_exc_m",   {31'd0, exc_m},   32'd0);
        checkOutput("rst_valid_m", {31'd0, valid_m}, 32'd0);
        checkOutput("rst_shadow",  {31'd0, shadow},  32'd0);
        checkOutput("rst_epc_m",   epc_m,            32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Overflow trap
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h3000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10,
                      32'h0, 1'b0, 2'b00, 10'd0);
        #1;
        checkOutput("ov_exccode_e", {27'd0, exccode_e}, 32'd12);
        stepCycle();
        checkOutput("ov_exc_m",     {31'd0, exc_m},     32'd1);
        checkOutput("ov_exccode_m", {27'd0, exccode_m}, 32'd12);
        checkOutput("ov_epc_m",     epc_m,              32'h3000);
        checkOutput("ov_badva",     badvaddr_m,         32'h0);
        checkOutput("ov_shadow",    {31'd0, shadow},    32'd1);
        checkOutput("ov_valid_m",   {31'd0, valid_m},   32'd1);
        flushCycle();
        checkOutput("fl_shadow",    {31'd0, shadow},    32'd0);
        checkOutput("fl_exc_m",     {31'd0, exc_m},     32'd0);

        // Misaligned word load
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h3004, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10,
                      32'h1002, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("adel_code",  {27'd0, exccode_m}, 32'd4);
        checkOutput("adel_badva", badvaddr_m,         32'h1002);
        flushCycle();

        // Misaligned word store
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h3008, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10,
                      32'h1002, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("ades_code",  {27'd0, exccode_m}, 32'd5);
        checkOutput("ades_badva", badvaddr_m,         32'h1002);
        flushCycle();

        // Byte load at odd address is legal
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h300C, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00,
                      32'h1003, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("byte_code",   {27'd0, exccode_m}, 32'd0);
        checkOutput("byte_valid",  {31'd0, valid_m},   32'd1);
        checkOutput("byte_shadow", {31'd0, shadow},    32'd0);

        // Half load at odd address faults
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h3010, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01,
                      32'h2001, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("half_code", {27'd0, exccode_m}, 32'd4);
        flushCycle();

        // Half store at even address is legal; aligned store with address overflow faults
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h3014, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01,
                      32'h2002, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("half_ok", {27'd0, exccode_m}, 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h3018, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10,
                      32'h2004, 1'b1, 2'b00, 10'd0);
        stepCycle();
        checkOutput("aovf_code",  {27'd0, exccode_m}, 32'd5);
        checkOutput("aovf_badva", badvaddr_m,         32'h2004);
        flushCycle();

        // Load and store both set resolves as a load
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h301C, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11,
                      32'h2006, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("rdwr_code", {27'd0, exccode_m}, 32'd4);
        flushCycle();

        // D-inherited AdEL beats overflow and externals; BadVAddr takes the PC
        applyStimulus(1'b1, 1'b0, 5'd4, 32'h3010, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10,
                      32'h5555, 1'b0, 2'b11, {5'd11, 5'd10});
        stepCycle();
        checkOutput("dcode_code",  {27'd0, exccode_m}, 32'd4);
        checkOutput("dcode_badva", badvaddr_m,         32'h3010);
        flushCycle();

        // External requests: lowest index wins
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h3020, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10,
                      32'h5555, 1'b0, 2'b11, {5'd11, 5'd10});
        stepCycle();
        checkOutput("ext0_code",  {27'd0, exccode_m}, 32'd10);
        checkOutput("ext0_badva", badvaddr_m,         32'h0);
        checkOutput("ext0_epc",   epc_m,              32'h3020);
        flushCycle();

        // Request with a zero code is skipped
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h3024, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10,
                      32'h0, 1'b0, 2'b11, {5'd11, 5'd0});
        stepCycle();
        checkOutput("ext1_code", {27'd0, exccode_m}, 32'd11);
        flushCycle();

        // Shadow: after an exception, younger instructions become bubbles
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h3100, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10,
                      32'h0, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("sh_start", {31'd0, shadow}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 5'd0, 32'h3104 + 32'(4 * k), 1'b1, 1'b1, 1'b0, 1'b0,
                          2'b10, 32'h0, 1'b0, 2'b00, 10'd0);
            #1;
            checkOutput("sh_exccode_e", {27'd0, exccode_e}, 32'd0);
            stepCycle();
            checkOutput("sh_valid_m", {31'd0, valid_m},   32'd0);
            checkOutput("sh_code_m",  {27'd0, exccode_m}, 32'd0);
            checkOutput("sh_bd_m",    {31'd0, bd_m},      32'd0);
            checkOutput("sh_hold",    {31'd0, shadow},    32'd1);
        end
        flushCycle();
        checkOutput("sh_cleared", {31'd0, shadow}, 32'd0);
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h3200, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10,
                      32'h0, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("post_valid", {31'd0, valid_m},   32'd1);
        checkOutput("post_code",  {27'd0, exccode_m}, 32'd0);
        checkOutput("post_bd",    {31'd0, bd_m},      32'd1);
        checkOutput("post_epc",   epc_m,              32'h0);

        // Stall holds the register across changing inputs
        applyStimulus(1'b1, 1'b1, 5'd0, 32'h4000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10,
                      32'h0, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("st_code0", {27'd0, exccode_m}, 32'd12);
        @(negedge clk);
        stall = 1'b1;
        applyStimulus(1'b1, 1'b0, 5'd7, 32'h4444, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10,
                      32'h1002, 1'b0, 2'b00, 10'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 32'h4888, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01,
                      32'h1001, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("st_code", {27'd0, exccode_m}, 32'd12);
        checkOutput("st_epc",  epc_m,              32'h4000);
        checkOutput("st_bd",   {31'd0, bd_m},      32'd1);
        checkOutput("st_sh",   {31'd0, shadow},    32'd1);
        flushCycle();
        stall = 1'b0;
        checkOutput("stfl_exc",   {31'd0, exc_m},   32'd0);
        checkOutput("stfl_epc",   epc_m,            32'h0);
        checkOutput("stfl_shadow",{31'd0, shadow},  32'd0);

        // Flush and a new exception on the same edge: flush wins
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h4100, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10,
                      32'h0, 1'b0, 2'b00, 10'd0);
        flush = 1'b1;
        stepCycle();
        checkOutput("flx_exc",    {31'd0, exc_m},  32'd0);
        checkOutput("flx_shadow", {31'd0, shadow}, 32'd0);
        @(negedge clk);
        flush = 1'b0;

        // Asynchronous reset mid-stall while the shadow is active
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h5000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10,
                      32'h0, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("ar_pre", {31'd0, shadow}, 32'd1);
        stall = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("ar_shadow", {31'd0, shadow},    32'd0);
        checkOutput("ar_exc_m",  {31'd0, exc_m},     32'd0);
        checkOutput("ar_code_m", {27'd0, exccode_m}, 32'd0);
        checkOutput("ar_epc_m",  epc_m,              32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        stall   = 1'b0;

`ifdef EXC_STAGE_STATS_EN
        // Counter and last code after three accepted exceptions
        checkOutput("cnt_rst", {16'd0, exc_count}, 32'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h6000, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10,
                      32'h0, 1'b0, 2'b00, 10'd0);
        stepCycle();
        flushCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h6004, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10,
                      32'h6001, 1'b0, 2'b00, 10'd0);
        stepCycle();
        flushCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 32'h6008, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10,
                      32'h6002, 1'b0, 2'b00, 10'd0);
        stepCycle();
        checkOutput("cnt_three", {16'd0, exc_count}, 32'd3);
        checkOutput("last_code", {27'd0, last_code}, 32'd5);
        flushCycle();
`endif

        idleStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound on the run
    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no finish expected finish");
        $fatal(1, "[TB] run exceeded time bound");
    end

endmodule
